// File: rtl/fb_access_arbiter_pkg.sv
// Shared definitions for the frame-buffer access arbiter: default geometry,
// read-pipe depth, round-robin pointer type and RGB444 field helpers.
package fb_access_arbiter_pkg;

  localparam int FB_ADDR_W   = 17;
  localparam int FB_DATA_W   = 12;
  localparam int FB_DEPTH_PX = 76800;
  localparam int RD_LAT      = 3;

  typedef enum logic {
    RR_W0 = 1'b0,
    RR_W1 = 1'b1
  } rr_e;

  function automatic logic [3:0] rgb444_r(input logic [11:0] px);
    return px[11:8];
  endfunction

  function automatic logic [3:0] rgb444_g(input logic [11:0] px);
    return px[7:4];
  endfunction

  function automatic logic [3:0] rgb444_b(input logic [11:0] px);
    return px[3:0];
  endfunction

endpackage

// File: rtl/fb_starve_mon.sv
// Per-writer starvation monitor: counts consecutive waiting cycles and raises a
// sticky flag once the count reaches LIMIT.
module fb_starve_mon #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid,
  input  logic ready,
  output logic starve
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      if (!valid || ready) begin
        cnt <= '0;
      end else if (cnt != LIMIT_C) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == LIMIT_C) begin
        starve <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads have absolute priority with a fixed
// 3-cycle latency; the game writer and the clear engine round-robin the idle slots.
module fb_access_arbiter
  import fb_access_arbiter_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FB_DEPTH     = FB_DEPTH_PX,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_rd_en,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  input  logic              w0_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        starve_err,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);

  rr_e               rr_q;
  logic              grant_w0;
  logic              grant_w1;
  logic              wr_acc;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [RD_LAT-1:0] rd_vld_p;

  // Stage 0: combinational grant; readies are forced low while in reset
  always_comb begin
    grant_w0 = 1'b0;
    grant_w1 = 1'b0;
    if (reset_n && !vga_rd_en) begin
      if (w0_valid && (!w1_valid || rr_q == RR_W0)) begin
        grant_w0 = 1'b1;
      end else if (w1_valid) begin
        grant_w1 = 1'b1;
      end
    end
  end

  assign w0_ready = grant_w0;
  assign w1_ready = grant_w1;
  assign wr_acc   = grant_w0 | grant_w1;
  assign wr_addr  = grant_w1 ? w1_addr : w0_addr;
  assign wr_data  = grant_w1 ? w1_data : w0_data;
  assign wr_ok    = (wr_addr < DEPTH_A);

  // Stage 1: registered RAM issue, round-robin pointer and address error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_q      <= RR_W0;
      addr_err  <= 1'b0;
    end else begin
      mem_en <= vga_rd_en | (wr_acc & wr_ok);
      mem_we <= ~vga_rd_en & wr_acc & wr_ok;
      if (vga_rd_en) begin
        mem_addr <= vga_rd_addr;
      end else if (wr_acc && wr_ok) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      if (grant_w0) begin
        rr_q <= RR_W1;
      end else if (grant_w1) begin
        rr_q <= RR_W0;
      end
      if (wr_acc && !wr_ok) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Stages 1..3: read-valid shift register; data captured as the RAM returns it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld_p    <= '0;
      vga_rd_data <= '0;
    end else begin
      rd_vld_p <= {rd_vld_p[RD_LAT-2:0], vga_rd_en};
      if (rd_vld_p[RD_LAT-2]) begin
        vga_rd_data <= mem_rdata;
      end
    end
  end

  assign vga_rd_valid = rd_vld_p[RD_LAT-1];

  fb_starve_mon #(.LIMIT(STARVE_LIMIT)) u_starve_w0 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (w0_valid),
    .ready   (w0_ready),
    .starve  (starve_err[0])
  );

  fb_starve_mon #(.LIMIT(STARVE_LIMIT)) u_starve_w1 (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (w1_valid),
    .ready   (w1_ready),
    .starve  (starve_err[1])
  );

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: stimulus queues expected RAM issues and
// VGA read returns; a negedge monitor pops and compares them as the DUT emits them.
module tb_fb_access_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          vga_rd_en;
  logic [AW-1:0] vga_rd_addr;
  logic          vga_rd_valid;
  logic [DW-1:0] vga_rd_data;
  logic          w0_valid;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w0_ready;
  logic          w1_valid;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          w1_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    starve_err;
  logic          addr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_t;

  mem_t          mem_q[$];
  logic [DW-1:0] rd_q[$];

  always #5 clk = ~clk;

  fb_access_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vga_rd_en    (vga_rd_en),
    .vga_rd_addr  (vga_rd_addr),
    .vga_rd_valid (vga_rd_valid),
    .vga_rd_data  (vga_rd_data),
    .w0_valid     (w0_valid),
    .w0_addr      (w0_addr),
    .w0_data      (w0_data),
    .w0_ready     (w0_ready),
    .w1_valid     (w1_valid),
    .w1_addr      (w1_addr),
    .w1_data      (w1_data),
    .w1_ready     (w1_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .starve_err   (starve_err),
    .addr_err     (addr_err)
  );

  // RAM model: read data equals the low bits of the address, one cycle later
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[DW-1:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input int a);
    mem_t m;
    m.we = 1'b0; m.addr = AW'(a); m.data = '0;
    mem_q.push_back(m);
    rd_q.push_back(DW'(a));
  endtask

  task automatic push_wr(input int a, input int d);
    mem_t m;
    m.we = 1'b1; m.addr = AW'(a); m.data = DW'(d);
    mem_q.push_back(m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_rd_en = 1'b0; vga_rd_addr = '0;
    w0_valid = 1'b0; w0_addr = '0; w0_data = '0;
    w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Monitor: every RAM issue and every VGA return must match the queue head
  always @(negedge clk) begin
    mem_t m;
    logic [DW-1:0] e;
    if (vga_rd_valid === 1'b1) begin
      if (rd_q.size() == 0) chk("vga_rd_valid_unexpected", 32'(vga_rd_valid), 0);
      else begin
        e = rd_q.pop_front();
        chk("vga_rd_data", 32'(vga_rd_data), 32'(e));
      end
    end
    if (mem_en === 1'b1) begin
      if (mem_q.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 0);
      else begin
        m = mem_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset with every request asserted
    reset_n = 1'b0;
    vga_rd_en = 1'b1; vga_rd_addr = AW'(9);
    w0_valid = 1'b1; w0_addr = AW'(1); w0_data = 12'h123;
    w1_valid = 1'b1; w1_addr = AW'(2); w1_data = 12'h456;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_rd_valid", 32'(vga_rd_valid), 0);
      chk("rst_rd_data", 32'(vga_rd_data), 0);
      chk("rst_w0_ready", 32'(w0_ready), 0);
      chk("rst_w1_ready", 32'(w1_ready), 0);
      chk("rst_starve", 32'(starve_err), 0);
      chk("rst_addr_err", 32'(addr_err), 0);
    end
    step();
    idle_inputs();
    reset_n = 1'b1;

    // VGA stream of addresses 0..7 with the game writer blocked
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      vga_rd_en = 1'b1; vga_rd_addr = AW'(i);
      w0_valid = 1'b1; w0_addr = AW'(100); w0_data = 12'hABC;
      push_rd(i);
      @(negedge clk);
      chk("stream_w0_ready", 32'(w0_ready), 0);
    end
    step();
    vga_rd_en = 1'b0;
    push_wr(100, 'hABC);
    @(negedge clk);
    chk("stream_w0_after", 32'(w0_ready), 1);
    step();
    idle_inputs();
    repeat (5) step();

    // Round-robin: both writers valid, no VGA
    do_reset();
    step();
    w0_valid = 1'b1; w0_addr = AW'(10); w0_data = 12'h111;
    w1_valid = 1'b1; w1_addr = AW'(20); w1_data = 12'h222;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      if (i % 2 == 0) push_wr(10, 'h111);
      else push_wr(20, 'h222);
      @(negedge clk);
      chk("rr_w0_ready", 32'(w0_ready), 32'(i % 2 == 0));
      chk("rr_w1_ready", 32'(w1_ready), 32'(i % 2 == 1));
    end
    step();
    idle_inputs();
    repeat (3) step();

    // Priority: VGA toggles while W0 holds a request
    do_reset();
    step();
    w0_valid = 1'b1; w0_addr = AW'(5); w0_data = 12'h0F0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      vga_rd_en = (i % 2 == 0);
      vga_rd_addr = AW'(30 + i);
      if (i % 2 == 0) push_rd(30 + i);
      else push_wr(5, 'h0F0);
      @(negedge clk);
      chk("prio_w0_ready", 32'(w0_ready), 32'(i % 2 == 1));
    end
    step();
    idle_inputs();
    repeat (5) step();

    // Illegal write address, then the last legal address
    do_reset();
    step();
    w1_valid = 1'b1; w1_addr = AW'(76800); w1_data = 12'h777;
    @(negedge clk);
    chk("bad_w1_ready", 32'(w1_ready), 1);
    chk("bad_addr_err_pre", 32'(addr_err), 0);
    step();
    w1_addr = AW'(76799); w1_data = 12'h555;
    push_wr(76799, 'h555);
    @(negedge clk);
    chk("bad_mem_en", 32'(mem_en), 0);
    chk("bad_addr_err", 32'(addr_err), 1);
    chk("last_w1_ready", 32'(w1_ready), 1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("addr_err_sticky", 32'(addr_err), 1);
    repeat (3) step();

    // Starvation: VGA held 9 cycles with W0 waiting, limit 8
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      vga_rd_en = 1'b1; vga_rd_addr = AW'(i);
      w0_valid = 1'b1; w0_addr = AW'(1); w0_data = 12'h001;
      push_rd(i);
      @(negedge clk);
      if (i == 8) chk("starve_before", 32'(starve_err), 0);
    end
    step();
    vga_rd_en = 1'b0;
    push_wr(1, 'h001);
    @(negedge clk);
    chk("starve_set", 32'(starve_err), 1);
    chk("starve_w0_ready", 32'(w0_ready), 1);
    step();
    idle_inputs();
    repeat (4) step();
    @(negedge clk);
    chk("starve_sticky", 32'(starve_err), 1);

    // Reset asserted while a read is in flight
    do_reset();
    step();
    vga_rd_en = 1'b1; vga_rd_addr = AW'(3);
    mem_q.push_back('{we: 1'b0, addr: AW'(3), data: '0});
    step();
    vga_rd_en = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_rd_valid", 32'(vga_rd_valid), 0);
    repeat (4) step();

    chk("rd_q_empty", 32'(rd_q.size()), 0);
    chk("mem_q_empty", 32'(mem_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
